// File: rtl/trig_sched_pkg.sv
// Shared types and sizing helpers for the trigger readout scheduler.
package trig_sched_pkg;

  localparam int unsigned NSAMP_W = 5;
  localparam int unsigned STAT_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_XFER = 3'd2,
    ST_DONE = 3'd3,
    ST_GAP  = 3'd4
  } state_t;

  // Bits needed to hold values 0..n (never less than one bit).
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n == 0) ? 1 : $clog2(n + 1);
  endfunction

  // Saturating add of a small increment onto a statistics counter.
  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [STAT_W:0] sum;
    sum = {1'b0, a} + (STAT_W + 1)'(inc);
    return sum[STAT_W] ? {STAT_W{1'b1}} : sum[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/evt_fifo.sv
// One-bit-wide pending-event queue; accepts push on full when a pop happens in the same cycle.
module evt_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   din,
  input  logic                   pop,
  output logic                   head_c,
  output logic                   full_c,
  output logic                   empty_c,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en_c;
  logic             rd_en_c;

  assign empty_c = (count == '0);
  assign full_c  = (count == CW'(DEPTH));
  assign head_c  = mem[rd_ptr];
  assign rd_en_c = pop & ~empty_c;
  assign wr_en_c = push & (~full_c | rd_en_c);

  // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en_c) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en_c) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en_c, rd_en_c})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/trig_readout_sched.sv
// Queues L1A match/no-match decisions and grants the shared SCA readout path one event at a time.
// Define SCHED_STATS_EN to add saturating n_match/n_nomatch/n_drop counters.
module trig_readout_sched
  import trig_sched_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TO_CYC  = 63
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               matchr,
  input  logic               no_match,
  input  logic [NSAMP_W-1:0] nsamp,
  input  logic               clr_err,
  input  logic               rd_ack,
  output logic               rd_req,
  output logic               rd_match,
  output logic               rd_shift,
  output logic               evt_done,
  output logic               busy,
  output logic               ovfl,
  output logic               tmo,
  output logic               conflict
`ifdef SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0]  n_match,
  output logic [STAT_W-1:0]  n_nomatch,
  output logic [STAT_W-1:0]  n_drop
`endif
);

  localparam int unsigned CW     = $clog2(DEPTH) + 1;
  localparam int unsigned WAIT_W = cnt_bits(TO_CYC);
  localparam int unsigned GAP_W  = cnt_bits(GAP_CYC);

  state_t              state;
  logic                evt_type;
  logic [NSAMP_W-1:0]  ns_lat;
  logic [NSAMP_W-1:0]  samp_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [GAP_W-1:0]    gap_cnt;

  logic                head_c;
  logic                full_c;
  logic                empty_c;
  logic [CW-1:0]       count;

  logic                push_req_c;
  logic                push_ok_c;
  logic                pop_c;
  logic                drop_c;
  logic                tmo_set_c;
  logic [CW-1:0]       count_nxt_c;
  logic                idle_busy_c;

  // A simultaneous MATCHR/NO_MATCH is queued as a match.
  assign push_req_c  = matchr | no_match;
  assign pop_c       = (state == ST_IDLE) & ~empty_c;
  assign push_ok_c   = push_req_c & (~full_c | pop_c);
  assign drop_c      = push_req_c & full_c & ~pop_c;
  assign tmo_set_c   = (state == ST_REQ) & ~rd_ack & (wait_cnt == WAIT_W'(TO_CYC - 1));
  assign count_nxt_c = count + CW'(push_ok_c) - CW'(pop_c);
  assign idle_busy_c = (count_nxt_c != '0);

  evt_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push_req_c),
    .din     (matchr),
    .pop     (pop_c),
    .head_c  (head_c),
    .full_c  (full_c),
    .empty_c (empty_c),
    .count   (count)
  );

  // Scheduler FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      evt_type <= 1'b0;
      ns_lat   <= '0;
      samp_cnt <= '0;
      wait_cnt <= '0;
      gap_cnt  <= '0;
      rd_req   <= 1'b0;
      rd_match <= 1'b0;
      rd_shift <= 1'b0;
      evt_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_req   <= 1'b0;
      rd_match <= 1'b0;
      rd_shift <= 1'b0;
      evt_done <= 1'b0;
      busy     <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!empty_c) begin
            state    <= ST_REQ;
            evt_type <= head_c;
            ns_lat   <= nsamp;
            wait_cnt <= '0;
            rd_req   <= 1'b1;
            rd_match <= head_c;
          end else begin
            busy <= idle_busy_c;
          end
        end
        ST_REQ: begin
          if (rd_ack) begin
            if (evt_type && (ns_lat != '0)) begin
              state    <= ST_XFER;
              samp_cnt <= '0;
              rd_shift <= 1'b1;
              rd_match <= 1'b1;
            end else begin
              state    <= ST_DONE;
              evt_done <= 1'b1;
            end
          end else if (tmo_set_c) begin
            gap_cnt <= '0;
            if (GAP_CYC == 0) begin
              state <= ST_IDLE;
              busy  <= idle_busy_c;
            end else begin
              state <= ST_GAP;
            end
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            rd_req   <= 1'b1;
            rd_match <= evt_type;
          end
        end
        ST_XFER: begin
          if (samp_cnt == ns_lat - NSAMP_W'(1)) begin
            state    <= ST_DONE;
            evt_done <= 1'b1;
          end else begin
            samp_cnt <= samp_cnt + NSAMP_W'(1);
            rd_shift <= 1'b1;
            rd_match <= 1'b1;
          end
        end
        ST_DONE: begin
          gap_cnt <= '0;
          if (GAP_CYC == 0) begin
            state <= ST_IDLE;
            busy  <= idle_busy_c;
          end else begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
            state <= ST_IDLE;
            busy  <= idle_busy_c;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= idle_busy_c;
        end
      endcase
    end
  end

  // Sticky error flags: a set in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovfl     <= 1'b0;
      tmo      <= 1'b0;
      conflict <= 1'b0;
    end else begin
      ovfl     <= drop_c | (ovfl & ~clr_err);
      tmo      <= tmo_set_c | (tmo & ~clr_err);
      conflict <= matchr & no_match;
    end
  end

`ifdef SCHED_STATS_EN
  logic       done_now_c;
  logic [1:0] drop_inc_c;

  assign done_now_c = (state == ST_DONE);
  assign drop_inc_c = 2'(drop_c) + 2'(tmo_set_c);

  // Serviced counts tick on the EVT_DONE cycle; drops count queue overflows and ACK timeouts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_match   <= '0;
      n_nomatch <= '0;
      n_drop    <= '0;
    end else if (clr_err) begin
      n_match   <= STAT_W'(done_now_c & evt_type);
      n_nomatch <= STAT_W'(done_now_c & ~evt_type);
      n_drop    <= STAT_W'(drop_inc_c);
    end else begin
      n_match   <= sat_add(n_match, 2'(done_now_c & evt_type));
      n_nomatch <= sat_add(n_nomatch, 2'(done_now_c & ~evt_type));
      n_drop    <= sat_add(n_drop, drop_inc_c);
    end
  end
`endif

endmodule

// File: tb/tb_trig_readout_sched.sv
// Randomized bench for trig_readout_sched against a timestamp-based event scoreboard.
module tb_trig_readout_sched;

  localparam int DEPTH = 8;
  localparam int GAP   = 2;
  localparam int TO    = 63;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       matchr   = 1'b0;
  logic       no_match = 1'b0;
  logic [4:0] nsamp    = 5'd0;
  logic       clr_err  = 1'b0;
  logic       rd_ack   = 1'b0;
  logic       rd_req, rd_match, rd_shift, evt_done, busy, ovfl, tmo, conflict;
`ifdef SCHED_STATS_EN
  logic [15:0] n_match, n_nomatch, n_drop;
`endif

  always #5 clk = ~clk;

  trig_readout_sched #(
    .DEPTH   (DEPTH),
    .GAP_CYC (GAP),
    .TO_CYC  (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .matchr   (matchr),
    .no_match (no_match),
    .nsamp    (nsamp),
    .clr_err  (clr_err),
    .rd_ack   (rd_ack),
    .rd_req   (rd_req),
    .rd_match (rd_match),
    .rd_shift (rd_shift),
    .evt_done (evt_done),
    .busy     (busy),
    .ovfl     (ovfl),
    .tmo      (tmo),
    .conflict (conflict)
`ifdef SCHED_STATS_EN
    ,
    .n_match   (n_match),
    .n_nomatch (n_nomatch),
    .n_drop    (n_drop)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending queue plus timestamps of the event in service.
  bit q[$];
  int k;
  int idle_at;
  bit ev_pend;
  int g;
  bit ev_type;
  int ev_ns;
  int shift_lo, shift_hi, done_at;
  bit m_ovfl, m_tmo, m_conf;
  bit p_matchr, p_nomatch, p_clr, p_ack;
  int p_nsamp;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
    end
  endtask

  task automatic model_reset();
    q.delete();
    k = 0; idle_at = 0; ev_pend = 0; g = 0; ev_type = 0; ev_ns = 0;
    shift_lo = 1; shift_hi = 0; done_at = -1;
    m_ovfl = 0; m_tmo = 0; m_conf = 0;
    p_matchr = 0; p_nomatch = 0; p_clr = 0; p_ack = 0; p_nsamp = 0;
  endtask

  // Apply the inputs of cycle k-1 to the model, giving expectations for cycle k.
  task automatic model_step();
    int occ;
    bit pop, drop, tset;
    k++;
    occ  = q.size();
    pop  = !ev_pend && ((k - 1) >= idle_at) && (occ > 0);
    drop = 0;
    tset = 0;
    if (pop) begin
      ev_type = q.pop_front();
      ev_ns   = p_nsamp;
      g       = k;
      ev_pend = 1;
    end
    if (p_matchr || p_nomatch) begin
      if (occ == DEPTH && !pop) drop = 1;
      else q.push_back(p_matchr);
    end
    if (ev_pend && (k - 1) >= g) begin
      if (p_ack) begin
        ev_pend = 0;
        if (ev_type && ev_ns != 0) begin
          shift_lo = k; shift_hi = k + ev_ns - 1; done_at = k + ev_ns;
        end else begin
          shift_lo = 1; shift_hi = 0; done_at = k;
        end
        idle_at = done_at + GAP + 1;
      end else if ((k - 1) == g + TO - 1) begin
        ev_pend = 0;
        tset    = 1;
        idle_at = k + GAP;
      end
    end
    m_ovfl = drop | (m_ovfl & !p_clr);
    m_tmo  = tset | (m_tmo & !p_clr);
    m_conf = p_matchr & p_nomatch;
  endtask

  task automatic compare();
    bit e_req, e_shift;
    e_req   = ev_pend && (k >= g);
    e_shift = (k >= shift_lo) && (k <= shift_hi);
    check("rd_req",   rd_req,   e_req);
    check("rd_match", rd_match, e_req ? ev_type : e_shift);
    check("rd_shift", rd_shift, e_shift);
    check("evt_done", evt_done, k == done_at);
    check("busy",     busy,     ev_pend || (k < idle_at) || (q.size() > 0));
    check("ovfl",     ovfl,     m_ovfl);
    check("tmo",      tmo,      m_tmo);
    check("conflict", conflict, m_conf);
  endtask

  // One clock: sample and check at the falling edge, then drive the next inputs.
  task automatic cycle(input int push_pct, input int ack_pct, input int conf_pct, input int clr_pm);
    bit push, both;
    @(negedge clk);
    model_step();
    compare();
    push = ($urandom_range(99) < push_pct);
    both = ($urandom_range(99) < conf_pct);
    if (push && both) begin
      matchr = 1; no_match = 1;
    end else if (push) begin
      matchr = $urandom_range(1); no_match = ~matchr;
    end else begin
      matchr = 0; no_match = 0;
    end
    nsamp   = 5'($urandom_range(10));
    rd_ack  = ($urandom_range(99) < ack_pct);
    clr_err = ($urandom_range(999) < clr_pm);
    p_matchr = matchr; p_nomatch = no_match; p_nsamp = int'(nsamp);
    p_ack = rd_ack; p_clr = clr_err;
  endtask

  task automatic zero_inputs();
    matchr = 0; no_match = 0; nsamp = 5'd0; clr_err = 0; rd_ack = 0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_req",  rd_req, 0);
    check("rst_flags", {ovfl, tmo, conflict, evt_done, rd_shift, rd_match}, 0);
    rst_n = 1;
    model_reset();
  endtask

  initial begin
    bit seen;
    zero_inputs();
    rst_n = 0;
    repeat (3) @(negedge clk);
    release_reset();

    repeat (1500) cycle(10, 40, 10, 5);
    repeat (80) cycle(0, 100, 0, 0);

    // Overfill with ACK withheld: overflow, then every queued event times out.
    repeat (20) cycle(80, 0, 20, 0);
    repeat (620) cycle(0, 0, 0, 0);
    repeat (3) cycle(0, 100, 0, 1000);
    repeat (60) cycle(0, 100, 0, 0);

    repeat (800) cycle(60, 70, 10, 2);
    repeat (150) cycle(0, 100, 0, 0);

    // Asynchronous reset while samples are streaming.
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cycle(25, 100, 0, 0);
      seen = rd_shift;
    end
    check("xfer_seen", seen, 1);
    zero_inputs();
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("async_shift", rd_shift, 0);
    check("async_req",   rd_req, 0);
    check("async_busy",  busy, 0);
    check("async_done",  evt_done, 0);
    repeat (2) @(negedge clk);
    release_reset();

    repeat (400) cycle(15, 50, 10, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
